// File: rtl/pck_control.sv
// rtl/pck_control.sv - shared ALU operation codes, FSM states and flag indices
package pck_control;

  typedef enum logic [3:0] {
    alu_add   = 4'd0,
    alu_sub   = 4'd1,
    alu_and   = 4'd2,
    alu_or    = 4'd3,
    alu_xor   = 4'd4,
    alu_slt   = 4'd5,
    alu_sltu  = 4'd6,
    alu_sll   = 4'd7,
    alu_srl   = 4'd8,
    alu_sra   = 4'd9,
    alu_cpa   = 4'd10,
    alu_cpb   = 4'd11,
    alu_mul   = 4'd12,
    alu_mulhu = 4'd13
  } sel_alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  function automatic logic is_mul_op(input sel_alu_op_e op);
    return (op == alu_mul) || (op == alu_mulhu);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative unsigned shift-add multiplier, one step per cycle
module alu_mul_iter #(
  parameter int BITS = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [BITS-1:0]   i_a,
  input  logic [BITS-1:0]   i_b,
  output logic              o_done,
  output logic [2*BITS-1:0] o_prod
);

  localparam int CNT_BITS = $clog2(BITS);

  logic                busy;
  logic [CNT_BITS-1:0] cnt;
  logic [BITS-1:0]     mcand;
  logic [2*BITS-1:0]   acc;
  logic [2*BITS-1:0]   acc_next;
  logic [BITS:0]       sum;

  // Multiplier sits in the low half and is shifted out as the product grows in.
  always_comb begin
    sum      = {1'b0, acc[2*BITS-1:BITS]} + (acc[0] ? {1'b0, mcand} : {(BITS+1){1'b0}});
    acc_next = {sum, acc[BITS-1:1]};
  end

  // The final step's value is exposed combinationally so the result lands on that edge.
  assign o_done = busy && (cnt == CNT_BITS'(BITS - 1));
  assign o_prod = acc_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      mcand <= '0;
      acc   <= '0;
    end else if (i_start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      mcand <= i_a;
      acc   <= {{BITS{1'b0}}, i_b};
    end else if (busy) begin
      acc <= acc_next;
      cnt <= cnt + 1'b1;
      if (o_done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with flags, iterative multiply and valid/ready on both sides
module alu_mc
  import pck_control::*;
#(
  parameter int BITS = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  sel_alu_op_e i_sel_op,
  input  logic [BITS-1:0] i_op_a,
  input  logic [BITS-1:0] i_op_b,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [BITS-1:0] o_res,
  output logic [3:0]  o_flags
);

  localparam int SHIFT_BITS = $clog2(BITS);
  localparam int MSB        = BITS - 1;

  alu_state_e             state;
  logic                   sel_hi;
  logic                   accept;
  logic                   mul_start;
  logic                   mul_done;
  logic [2*BITS-1:0]      mul_prod;
  logic [BITS-1:0]        mul_res;
  logic [3:0]             mul_flags;
  logic [SHIFT_BITS-1:0]  shamt;
  logic [BITS:0]          add_w;
  logic [BITS-1:0]        diff;
  logic [BITS-1:0]        res_c;
  logic [3:0]             flags_c;
  logic                   carry_c;
  logic                   ovf_c;

  assign o_ready   = (state == IDLE) && (!o_valid || i_ready);
  assign accept    = i_valid && o_ready;
  assign mul_start = accept && is_mul_op(i_sel_op);
  assign shamt     = i_op_b[SHIFT_BITS-1:0];

  always_comb begin
    add_w   = {1'b0, i_op_a} + {1'b0, i_op_b};
    diff    = i_op_a - i_op_b;
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    case (i_sel_op)
      alu_add: begin
        res_c   = add_w[BITS-1:0];
        carry_c = add_w[BITS];
        ovf_c   = (i_op_a[MSB] == i_op_b[MSB]) && (add_w[MSB] != i_op_a[MSB]);
      end
      alu_sub: begin
        res_c   = diff;
        carry_c = i_op_a < i_op_b;
        ovf_c   = (i_op_a[MSB] != i_op_b[MSB]) && (diff[MSB] != i_op_a[MSB]);
      end
      alu_and:  res_c = i_op_a & i_op_b;
      alu_or:   res_c = i_op_a | i_op_b;
      alu_xor:  res_c = i_op_a ^ i_op_b;
      alu_slt:  res_c = {{(BITS-1){1'b0}}, $signed(i_op_a) < $signed(i_op_b)};
      alu_sltu: res_c = {{(BITS-1){1'b0}}, i_op_a < i_op_b};
      alu_sll:  res_c = i_op_a << shamt;
      alu_srl:  res_c = i_op_a >> shamt;
      alu_sra:  res_c = $unsigned($signed(i_op_a) >>> shamt);
      alu_cpa:  res_c = i_op_a;
      alu_cpb:  res_c = i_op_b;
      default:  res_c = '0;
    endcase
    flags_c         = '0;
    flags_c[FLAG_Z] = (res_c == '0);
    flags_c[FLAG_N] = res_c[MSB];
    flags_c[FLAG_C] = carry_c;
    flags_c[FLAG_V] = ovf_c;
  end

  always_comb begin
    mul_res           = sel_hi ? mul_prod[2*BITS-1:BITS] : mul_prod[BITS-1:0];
    mul_flags         = '0;
    mul_flags[FLAG_Z] = (mul_res == '0);
    mul_flags[FLAG_N] = mul_res[MSB];
  end

  alu_mul_iter #(.BITS(BITS)) u_mul (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (mul_start),
    .i_a     (i_op_a),
    .i_b     (i_op_b),
    .o_done  (mul_done),
    .o_prod  (mul_prod)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      sel_hi  <= 1'b0;
      o_valid <= 1'b0;
      o_res   <= '0;
      o_flags <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mul_start) begin
            state   <= MUL;
            sel_hi  <= (i_sel_op == alu_mulhu);
            o_valid <= 1'b0;
          end else if (accept) begin
            o_valid <= 1'b1;
            o_res   <= res_c;
            o_flags <= flags_c;
          end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
          end
        end
        MUL: begin
          if (mul_done) begin
            state   <= IDLE;
            o_valid <= 1'b1;
            o_res   <= mul_res;
            o_flags <= mul_flags;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
